// File: rtl/step_pulse_conditioner_pkg.sv
// Shared types and constants for the step pulse conditioner.
package step_pulse_conditioner_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_t;

    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

    // Largest of the three timing parameters; sizes the shared down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/step_dir_fifo.sv
// Pending-step buffer: 1-bit direction per entry, sync push/pop, push on a
// full FIFO is legal when a pop happens in the same cycle.
module step_dir_fifo #(
    parameter int DEPTH = 4
) (
    input  logic PCLK,
    input  logic PRESERN,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [DEPTH-1:0] mem;

    // Read/write pointers carry an extra wrap bit to tell full from empty.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage; contents are don't-care while empty so no reset needed.
    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/step_pulse_conditioner.sv
// Single-axis step/dir conditioner: buffers step requests, enforces driver
// dir-setup and pulse high/low minima, tracks signed axis position.
module step_pulse_conditioner
    import step_pulse_conditioner_pkg::*;
#(
    parameter int DIR_SETUP_CYC  = 10,
    parameter int PULSE_HIGH_CYC = 100,
    parameter int PULSE_LOW_CYC  = 100,
    parameter int FIFO_DEPTH     = 4,
    parameter int POS_W          = 32
) (
    input  logic             PCLK,
    input  logic             PRESERN,
    input  logic             enable,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             pos_clear,
    input  logic             clr_overrun,
    output logic             step_out,
    output logic             dir_out,
    output logic             busy,
    output logic             overrun,
    output logic [POS_W-1:0] position
);

    localparam int TMAX = max3(DIR_SETUP_CYC, PULSE_HIGH_CYC, PULSE_LOW_CYC);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] T_SETUP = TW'(DIR_SETUP_CYC - 1);
    localparam logic [TW-1:0] T_HIGH  = TW'(PULSE_HIGH_CYC - 1);
    localparam logic [TW-1:0] T_LOW   = TW'(PULSE_LOW_CYC - 1);

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          step_nxt, dir_nxt;
    logic          step_q;
    logic          rise, push, pop, try_pop, enter_high;
    logic          fifo_dout, fifo_full, fifo_empty;

    assign rise = step_in & ~step_q;
    // A full FIFO still accepts the edge if an entry leaves this cycle.
    assign push = rise & (~fifo_full | pop);
    assign busy = (state != S_IDLE) | ~fifo_empty;

    step_dir_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .push    (push),
        .pop     (pop),
        .din     (dir_in),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Step input edge register.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) step_q <= 1'b0;
        else          step_q <= step_in;
    end

    // FSM state, shared timer and registered driver outputs.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state    <= S_IDLE;
            timer    <= '0;
            step_out <= 1'b0;
            dir_out  <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            step_out <= step_nxt;
            dir_out  <= dir_nxt;
        end
    end

    // Next-state logic; LOW expiry falls through to the IDLE pop so pulses
    // can run back to back.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        step_nxt   = step_out;
        dir_nxt    = dir_out;
        try_pop    = 1'b0;
        pop        = 1'b0;
        enter_high = 1'b0;
        unique case (state)
            S_IDLE: try_pop = 1'b1;
            S_SETUP: begin
                if (timer == '0) enter_high = 1'b1;
                else             timer_nxt  = timer - 1'b1;
            end
            S_HIGH: begin
                if (timer == '0) begin
                    state_nxt = S_LOW;
                    step_nxt  = 1'b0;
                    timer_nxt = T_LOW;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_LOW: begin
                if (timer == '0) begin
                    state_nxt = S_IDLE;
                    try_pop   = 1'b1;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (try_pop && enable && !fifo_empty) begin
            pop = 1'b1;
            if (fifo_dout != dir_out) begin
                dir_nxt   = fifo_dout;
                timer_nxt = T_SETUP;
                state_nxt = S_SETUP;
            end else begin
                enter_high = 1'b1;
            end
        end
        if (enter_high) begin
            state_nxt = S_HIGH;
            step_nxt  = 1'b1;
            timer_nxt = T_HIGH;
        end
    end

    // Position counts on HIGH entry; clear takes priority over the count.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN)        position <= '0;
        else if (pos_clear)  position <= '0;
        else if (enter_high) position <= (dir_nxt == DIR_POS) ? position + POS_W'(1)
                                                              : position - POS_W'(1);
    end

    // Sticky overrun: a dropped edge beats a same-cycle clear.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN)                       overrun <= 1'b0;
        else if (rise && fifo_full && !pop) overrun <= 1'b1;
        else if (clr_overrun)               overrun <= 1'b0;
    end

endmodule

// File: tb/tb_step_pulse_conditioner.sv
// Bench for step_pulse_conditioner: directed cases plus a random run, with a
// monitor-side scoreboard of accepted step directions.
module tb_step_pulse_conditioner;

    localparam int DS    = 2;
    localparam int PH    = 3;
    localparam int PL    = 3;
    localparam int DEPTH = 4;
    localparam int POS_W = 8;

    logic             PCLK = 1'b0;
    logic             PRESERN;
    logic             enable, step_in, dir_in, pos_clear, clr_overrun;
    logic             step_out, dir_out, busy, overrun;
    logic [POS_W-1:0] position;

    int total = 0;
    int bad   = 0;

    // monitor / scoreboard state
    logic             exp_q[$];
    logic             ps, pd, bench_stepq, m_step, m_dir, m_rise, m_pop;
    bit               setup_pend;
    int               dir_age, high_len, low_len, last_gap, last_rise, cyc;
    int               rises = 0, drops = 0, pulses = 0;
    logic [POS_W-1:0] pos_exp;

    int r0, p0, d0, n;

    step_pulse_conditioner #(
        .DIR_SETUP_CYC  (DS),
        .PULSE_HIGH_CYC (PH),
        .PULSE_LOW_CYC  (PL),
        .FIFO_DEPTH     (DEPTH),
        .POS_W          (POS_W)
    ) dut (
        .PCLK        (PCLK),
        .PRESERN     (PRESERN),
        .enable      (enable),
        .step_in     (step_in),
        .dir_in      (dir_in),
        .pos_clear   (pos_clear),
        .clr_overrun (clr_overrun),
        .step_out    (step_out),
        .dir_out     (dir_out),
        .busy        (busy),
        .overrun     (overrun),
        .position    (position)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step_edge(input logic d);
        @(negedge PCLK); step_in = 1'b1; dir_in = d;
        @(negedge PCLK); step_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        @(negedge PCLK);
        while (busy && k < budget) begin
            @(negedge PCLK);
            k++;
        end
        chk("idle", busy, 0);
    endtask

    // Monitor: infers pops from dir_out changes / step_out rises, checks the
    // popped direction against the scoreboard and checks pulse timing.
    initial begin
        cyc = 0; last_rise = 0; last_gap = 0;
        forever begin
            @(posedge PCLK);
            cyc++;
            if (!PRESERN) begin
                exp_q.delete();
                ps = 0; pd = 0; bench_stepq = 0; setup_pend = 0;
                dir_age = 0; high_len = 0; low_len = 100; pos_exp = '0;
            end else begin
                m_step = step_in; m_dir = dir_in;
                #1;
                m_rise = m_step && !bench_stepq;
                bench_stepq = m_step;
                m_pop = (dir_out !== pd) || (step_out && !ps && !setup_pend);
                if (dir_out !== pd) begin
                    chk("dir_stable", {ps, step_out}, 0);
                    setup_pend = 1; dir_age = 0;
                end else begin
                    dir_age++;
                end
                if (m_pop) begin
                    if (exp_q.size() == 0) chk("pop_empty", 1, 0);
                    else                   chk("pop_dir", dir_out, exp_q.pop_front());
                end
                if (m_rise) begin
                    rises++;
                    if (exp_q.size() < DEPTH) begin
                        exp_q.push_back(m_dir);
                        pos_exp = m_dir ? pos_exp + 1'b1 : pos_exp - 1'b1;
                    end else begin
                        drops++;
                        chk("ovr_set", overrun, 1);
                    end
                end
                if (step_out && !ps) begin
                    pulses++;
                    if (setup_pend) chk("dir_setup", dir_age, DS);
                    chk("low_min", low_len >= PL, 1);
                    last_gap = cyc - last_rise; last_rise = cyc;
                    high_len = 1; setup_pend = 0;
                end else if (step_out && ps) begin
                    high_len++;
                end else if (!step_out && ps) begin
                    chk("high_len", high_len, PH);
                    low_len = 1;
                end else begin
                    low_len++;
                end
                ps = step_out; pd = dir_out;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        PRESERN = 0; enable = 0; step_in = 0; dir_in = 0; pos_clear = 0; clr_overrun = 0;
        repeat (2) @(negedge PCLK);
        chk("rst_step", step_out, 0);
        chk("rst_dir",  dir_out,  0);
        chk("rst_busy", busy,     0);
        chk("rst_ovr",  overrun,  0);
        chk("rst_pos",  position, 0);
        PRESERN = 1; enable = 1;

        // 1: single negative step, no setup phase
        @(negedge PCLK); step_in = 1; dir_in = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK); step_in = 0;
            chk("t1_step", step_out, (i >= 1 && i <= 3));
            chk("t1_busy", busy, (i < 7));
        end
        chk("t1_pos", position, 'hFF);

        // 2: direction change inserts setup before the pulse
        @(negedge PCLK); step_in = 1; dir_in = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK); step_in = 0;
            chk("t2_dir",  dir_out,  (i >= 1));
            chk("t2_step", step_out, (i >= 3 && i <= 5));
        end
        wait_idle(20);
        chk("t2_pos", position, 0);

        // 3: queue while disabled, overflow, then drain
        enable = 0; d0 = drops; p0 = pulses;
        for (int i = 0; i < 6; i++) step_edge(1);
        chk("t3_ovr",   overrun, 1);
        chk("t3_drops", drops - d0, 2);
        repeat (5) @(negedge PCLK);
        chk("t3_nopulse", pulses - p0, 0);
        chk("t3_busy",    busy, 1);
        enable = 1;
        wait_idle(100);
        chk("t3_pulses", pulses - p0, 4);
        chk("t3_pos",    position, 4);
        chk("t3_period", last_gap, PH + PL);
        clr_overrun = 1;
        @(negedge PCLK); clr_overrun = 0;
        chk("t3_clr", overrun, 0);

        // 4: signed wrap at the top of the position range, then clear-wins
        for (int i = 0; i < 122; i++) begin step_edge(1); wait_idle(50); end
        chk("t4_7e", position, 'h7E);
        step_edge(1); wait_idle(50);
        chk("t4_7f", position, 'h7F);
        step_edge(1); wait_idle(50);
        chk("t4_wrap", position, 'h80);
        @(negedge PCLK); step_in = 1; dir_in = 1;
        @(negedge PCLK); step_in = 0; pos_clear = 1;
        @(negedge PCLK); pos_clear = 0;
        chk("t4_hi",  step_out, 1);
        chk("t4_clr", position, 0);
        wait_idle(50);
        chk("t4_clr2", position, 0);

        // 5: reset in the middle of a pulse with steps queued
        enable = 0;
        for (int i = 0; i < 4; i++) step_edge(1);
        enable = 1;
        n = 0;
        while (!step_out && n < 20) begin @(negedge PCLK); n++; end
        chk("t5_hi", step_out, 1);
        #2 PRESERN = 0;
        #1;
        chk("t5_step", step_out, 0);
        chk("t5_busy", busy, 0);
        chk("t5_pos",  position, 0);
        chk("t5_dir",  dir_out, 0);
        @(negedge PCLK); PRESERN = 1;
        p0 = pulses;
        repeat (30) @(negedge PCLK);
        chk("t5_nopulse", pulses - p0, 0);
        chk("t5_idle",    busy, 0);

        // 6: random traffic against the scoreboard
        r0 = rises; p0 = pulses; d0 = drops;
        for (int i = 0; i < 800; i++) begin
            @(negedge PCLK);
            step_in = 1'($urandom_range(0, 1));
            dir_in  = 1'($urandom_range(0, 1));
            enable  = ($urandom_range(0, 7) != 0);
        end
        @(negedge PCLK); step_in = 0; enable = 1;
        wait_idle(300);
        chk("t6_count", (pulses - p0) + (drops - d0), rises - r0);
        chk("t6_pos",   position, pos_exp);
        chk("t6_q",     exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
